// File: rtl/bfs_pkg.sv
// Shared types and default widths for the BFS level sequencer.
package bfs_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int LVL_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPMV   = 3'd1,
        ST_LG_RUN = 3'd2,
        ST_LG_REL = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/bfs_sat_accum.sv
// Saturating accumulator: clear wins over add, sum sticks at all-ones.
module bfs_sat_accum
    import bfs_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         add_en,
    input  logic [W-1:0] add_val,
    output logic [W-1:0] sum
);

    logic [W-1:0] sum_q, sum_d;
    logic [W:0]   sum_wide;

    always_comb begin
        sum_wide = {1'b0, sum_q} + {1'b0, add_val};
        sum_d    = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/bfs_level_sequencer.sv
// BFS iteration controller: runs SpMV then level generation per level until
// a level adds no vertices or the level limit is reached.
//
// state  | meaning
// IDLE   | waiting for io_start; stats from the last run stay readable
// SPMV   | frontier expansion running, waiting for spmv_done
// LG_RUN | lg_start held, waiting for lg_finished, then capture write count
// LG_REL | lg_start dropped, waiting for level generator to go idle
// CHECK  | bump level, accumulate, decide converge / limit / next level
// DONE   | io_done held until io_start is released
module bfs_level_sequencer
    import bfs_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LVL_W = LVL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_start,
    input  logic [CNT_W-1:0] io_vertexCount,
    input  logic [LVL_W-1:0] io_maxLevels,
    output logic             io_busy,
    output logic             io_done,
    output logic             io_limitHit,
    output logic [LVL_W-1:0] io_levelCount,
    output logic [CNT_W-1:0] io_totalVisited,
    output logic [CNT_W-1:0] io_lastFrontier,
    output logic             spmv_start,
    input  logic             spmv_done,
    output logic             lg_start,
    output logic [CNT_W-1:0] lg_bitCount,
    input  logic             lg_finished,
    input  logic [CNT_W-1:0] lg_writeCount
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic [LVL_W-1:0] max_levels_q, max_levels_d;
    logic [LVL_W-1:0] level_count_q, level_count_d;
    logic [CNT_W-1:0] last_frontier_q, last_frontier_d;
    logic             limit_hit_q, limit_hit_d;
    logic [LVL_W-1:0] level_inc;
    logic             accum_clr;
    logic             accum_add;

    assign level_inc = level_count_q + {{(LVL_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d         = state_q;
        bit_count_d     = bit_count_q;
        max_levels_d    = max_levels_q;
        level_count_d   = level_count_q;
        last_frontier_d = last_frontier_q;
        limit_hit_d     = limit_hit_q;
        accum_clr       = 1'b0;
        accum_add       = 1'b0;
        spmv_start      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    bit_count_d     = io_vertexCount;
                    max_levels_d    = io_maxLevels;
                    level_count_d   = '0;
                    last_frontier_d = '0;
                    limit_hit_d     = 1'b0;
                    accum_clr       = 1'b1;
                    spmv_start      = 1'b1;
                    state_d         = ST_SPMV;
                end
            end
            ST_SPMV: begin
                if (spmv_done) begin
                    state_d = ST_LG_RUN;
                end
            end
            ST_LG_RUN: begin
                // Write count is only valid here; a restart clears it.
                if (lg_finished) begin
                    last_frontier_d = lg_writeCount;
                    state_d         = ST_LG_REL;
                end
            end
            ST_LG_REL: begin
                if (!lg_finished) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                level_count_d = level_inc;
                accum_add     = 1'b1;
                if (last_frontier_q == '0) begin
                    limit_hit_d = 1'b0;
                    state_d     = ST_DONE;
                end else if ((max_levels_q != '0) && (level_inc == max_levels_q)) begin
                    limit_hit_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    spmv_start = 1'b1;
                    state_d    = ST_SPMV;
                end
            end
            ST_DONE: begin
                if (!io_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            bit_count_q     <= '0;
            max_levels_q    <= '0;
            level_count_q   <= '0;
            last_frontier_q <= '0;
            limit_hit_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_count_q     <= bit_count_d;
            max_levels_q    <= max_levels_d;
            level_count_q   <= level_count_d;
            last_frontier_q <= last_frontier_d;
            limit_hit_q     <= limit_hit_d;
        end
    end

    bfs_sat_accum #(.W(CNT_W)) u_total (
        .clk     (clk),
        .reset   (reset),
        .clr     (accum_clr),
        .add_en  (accum_add),
        .add_val (last_frontier_q),
        .sum     (io_totalVisited)
    );

    assign io_busy         = (state_q == ST_SPMV) || (state_q == ST_LG_RUN) ||
                             (state_q == ST_LG_REL) || (state_q == ST_CHECK);
    assign io_done         = (state_q == ST_DONE);
    assign io_limitHit     = limit_hit_q;
    assign io_levelCount   = level_count_q;
    assign io_lastFrontier = last_frontier_q;
    assign lg_start        = (state_q == ST_LG_RUN);
    assign lg_bitCount     = bit_count_q;

endmodule

// File: doc/bfs_level_sequencer.md
Name: bfs_level_sequencer

Overview:
- Top-level iteration controller for the sparse-frontier BFS pipeline.
- Each BFS level runs in two phases: first the frontier-expansion (SpMV) engine, then the level generator.
- The level generator diffs the old and new visited bitmaps and emits the next-frontier indices.
- The block repeats levels until a level produces zero new vertices or a level limit is hit, and accumulates statistics for the host.

Parameters:
- CNT_W, 32, width of bit counts, write counts and the visited accumulator.
- LVL_W, 16, width of the level counter and level limit.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- io_start  in  1  host run request, level-sensitive; must be dropped after io_done to re-arm
- io_vertexCount  in  CNT_W  number of bitmap bits per level; sampled in IDLE on the start edge
- io_maxLevels  in  LVL_W  level limit; 0 means unlimited; sampled with io_vertexCount
- io_busy  out  1  high from start acceptance until DONE
- io_done  out  1  high in DONE
- io_limitHit  out  1  valid with io_done: 1 = stopped on limit, 0 = converged
- io_levelCount  out  LVL_W  completed levels
- io_totalVisited  out  CNT_W  sum of all level write counts, saturating
- io_lastFrontier  out  CNT_W  write count of the most recent level
- spmv_start  out  1  one-cycle pulse starting frontier expansion
- spmv_done  in  1  one-cycle pulse; expansion complete
- lg_start  out  1  level-generator start, level-held
- lg_bitCount  out  CNT_W  level-generator bit count
- lg_finished  in  1  level-generator finished, level
- lg_writeCount  in  CNT_W  level-generator write count

Behaviour:
- Reset values: all outputs 0; all counters 0; state IDLE. Reset asserted mid-run returns to IDLE immediately. spmv_start and lg_start drop asynchronously with reset.
- lg_bitCount is driven from a register loaded at start acceptance. It is stable for the whole run.
- States: IDLE, SPMV, LG_RUN, LG_REL, CHECK, DONE.
- IDLE:
  - On io_start=1: latch vertexCount and maxLevels; clear levelCount, totalVisited and lastFrontier; clear limitHit.
  - In the same cycle, assert spmv_start for that one cycle and go to SPMV.
  - io_busy rises in the next cycle.
- SPMV: wait for spmv_done. On spmv_done go to LG_RUN. spmv_start must be 0 throughout SPMV.
- LG_RUN:
  - Hold lg_start=1.
  - When lg_finished=1, register lg_writeCount into lastFrontier and go to LG_REL.
  - The level generator clears its write count when it is restarted, so the count is sampled only here.
- LG_REL:
  - lg_start=0. Wait for lg_finished=0 (the level generator returns to its idle state).
  - Then go to CHECK.
- CHECK, single cycle:
  - levelCount += 1 (wraps at 2^LVL_W).
  - totalVisited += lastFrontier, saturating at all-ones.
  - If lastFrontier==0: go to DONE with limitHit=0.
  - Else if maxLevels!=0 and the incremented levelCount==maxLevels: go to DONE with limitHit=1.
  - Else pulse spmv_start and go to SPMV.
  - Convergence takes priority when both conditions hold.
- DONE: io_done=1, io_busy=0. Outputs hold until io_start=0, then return to IDLE. The statistics remain readable in IDLE until the next start.
- Timing and glitches:
  - spmv_done arriving in the same cycle as spmv_start is ignored. SPMV samples only from the cycle after entry.
  - spmv_done pulses outside SPMV are ignored.
- Minimum latency per level: 1 (spmv_start) + spmv latency + lg latency + 2 (LG_REL, CHECK) cycles.
- io_vertexCount=0 is legal. The level generator finishes immediately with writeCount 0, so the run converges after 1 level.

Decomposition:
- Shared package bfs_pkg holds:
  - the state enum (3-bit encoding: IDLE=0, SPMV=1, LG_RUN=2, LG_REL=3, CHECK=4, DONE=5);
  - the CNT_W and LVL_W default constants.
- One natural sub-module, bfs_sat_accum: a CNT_W saturating accumulator with clear and add-enable, used for totalVisited.
- The FSM stays in the top-level module.

Test Plan:
- Convergence: vertexCount=128, maxLevels=0, write counts 5,12,0 -> 3 spmv_start pulses, io_done with levelCount=3, totalVisited=17, lastFrontier=0, limitHit=0.
- Level limit: maxLevels=2, write counts 7,9 -> done after 2 levels, limitHit=1, totalVisited=16, no third spmv_start.
- Handshake: hold lg_finished high for 10 cycles after lg_start drops -> the block stays in LG_REL and lg_start stays 0. Also check that lg_bitCount stays 128 throughout.
- Saturation: CNT_W=8, write counts 200,100,0 -> totalVisited=255.
- Reset mid-run: assert reset during LG_RUN -> lg_start, io_busy and counters go to 0 the same cycle, state IDLE. A subsequent start runs normally.
- Re-arm: hold io_start high after done -> no new run. Drop then raise io_start -> new run with the statistics cleared.
